// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder step per clock, LSB first.
// Result and carry are registered and announced by a one-cycle done pulse.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             co_q, co_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic s_bit;
  logic c_nxt;
  logic [WIDTH-1:0] r_nxt;

  assign s_bit = a_q[0] ^ b_q[0] ^ c_q;
  assign c_nxt = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));
  assign r_nxt = {s_bit, r_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    co_d    = co_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      // DONE accepts start exactly like IDLE for back-to-back adds
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          a_d     = a;
          b_d     = b;
          c_d     = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        c_d    = c_nxt;
        r_d    = r_nxt;
        busy_d = 1'b1;
        if (cnt_q == LAST) begin
          sum_d   = r_nxt;
          co_d    = c_nxt;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign carry_out = co_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry_out;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
  );

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    int           at;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      if (q.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        mon_e = q.pop_front();
        chk("sum", 32'(sum), 32'(mon_e.s));
        chk("carry_out", 32'(carry_out), 32'(mon_e.co));
        chk("done_cycle", 32'(cyc), 32'(mon_e.at));
        chk("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  // Drive operands with start; the next edge must accept them.
  task automatic accept(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] es, input logic ec);
    a     = av;
    b     = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    q.push_back('{s: es, co: ec, at: cyc + W});
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_drain(input int max);
    int n;
    n = 0;
    while (q.size() != 0 && n < max) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk("drain_queue", 32'(q.size()), 32'd0);
    q.delete();
  endtask

  logic [W-1:0] va [4] = '{8'h12, 8'h80, 8'hAA, 8'hC8};
  logic [W-1:0] vb [4] = '{8'h34, 8'h80, 8'h55, 8'h64};
  logic [W-1:0] vs [4] = '{8'h46, 8'h00, 8'hFF, 8'h2C};
  logic         vc [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    int n;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state, and idle with start low
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_carry", 32'(carry_out), 32'd0);
    end

    // 5A+3C, with an ignored start pulse mid-shift
    @(negedge clk);
    accept(8'h5A, 8'h3C, 8'h96, 1'b0);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    a     = 8'h01;
    b     = 8'h01;
    @(negedge clk);
    start = 1'b0;
    wait_drain(20);
    repeat (4) @(negedge clk);

    // carry out of the MSB
    accept(8'hFF, 8'h01, 8'h00, 1'b1);
    start = 1'b0;
    wait_drain(20);
    @(negedge clk);
    accept(8'hFF, 8'hFF, 8'hFE, 1'b1);
    start = 1'b0;
    wait_drain(20);
    repeat (4) @(negedge clk);
    chk("sum_hold", 32'(sum), 32'h0FE);
    chk("carry_hold", 32'(carry_out), 32'd1);

    // start held high: back-to-back adds every W+1 cycles
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        n = 0;
        while (done !== 1'b1 && n < 20) begin
          @(negedge clk);
          n++;
        end
        chk("b2b_done_seen", 32'(done), 32'd1);
      end
      accept(va[i], vb[i], vs[i], vc[i]);
    end
    start = 1'b0;
    wait_drain(40);
    @(negedge clk);

    // reset in the middle of a shift abandons the add
    accept(8'hFF, 8'h01, 8'h00, 1'b1);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_carry", 32'(carry_out), 32'd0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("midrst_no_done_sum", 32'(sum), 32'd0);

    // fresh add after reset
    accept(8'h7F, 8'h01, 8'h80, 1'b0);
    start = 1'b0;
    wait_drain(20);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
